// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths and the reserved "no producer" label,
// used by the instruction queue, reservation stations and CDB broadcaster.
package tomasulo_pkg;

  localparam int N_SRC_DEF   = 4;
  localparam int LABEL_W_DEF = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int NO_LABEL    = 0;

  // Index width that stays legal for a single-source configuration.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping around, and returns a one-hot grant.
module rr_arbiter
  import tomasulo_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int PTR_W = idxWidth(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_SRC-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < N_SRC; off++) begin
      idx = PTR_W'((int'(ptr) + off) % N_SRC);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: one holding slot per functional unit, round-robin
// selection of a full slot, and a registered broadcast of its label and result.
module cdb_broadcaster
  import tomasulo_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEF,
  parameter int LABEL_W = LABEL_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [N_SRC-1:0]           reqIn,
  input  logic [N_SRC*LABEL_W-1:0]   labelIn,
  input  logic [N_SRC*DATA_W-1:0]    dataIn,
  output logic [N_SRC-1:0]           ackOut,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata
);

  localparam int PTR_W = idxWidth(N_SRC);

  logic [N_SRC-1:0]   slotValid;
  logic [LABEL_W-1:0] slotLabel [N_SRC];
  logic [DATA_W-1:0]  slotData  [N_SRC];

  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   nextPtr;
  logic [PTR_W-1:0]   grantIdx;
  logic [N_SRC-1:0]   grant;
  logic [N_SRC-1:0]   captureEn;
  logic               anyGrant;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) uArb (
    .req   (slotValid),
    .ptr   (rrPtr),
    .grant (grant)
  );

  // A slot being drained this cycle can be refilled at the same edge.
  assign ackOut   = reqIn & (~slotValid | grant);
  assign anyGrant = |grant;

  always_comb begin
    captureEn = '0;
    for (int i = 0; i < N_SRC; i++) begin
      captureEn[i] = ackOut[i] &
                     (labelIn[i*LABEL_W +: LABEL_W] != LABEL_W'(NO_LABEL));
    end
  end

  always_comb begin
    grantIdx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) grantIdx = PTR_W'(i);
    end
  end

  assign nextPtr = (grantIdx == PTR_W'(N_SRC - 1)) ? '0 : grantIdx + PTR_W'(1);

  // Capture wins over the grant clear so a same-cycle refill is not lost.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      slotValid <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        slotLabel[i] <= '0;
        slotData[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (captureEn[i]) begin
          slotValid[i] <= 1'b1;
          slotLabel[i] <= labelIn[i*LABEL_W +: LABEL_W];
          slotData[i]  <= dataIn[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slotValid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rrPtr <= '0;
    end else if (anyGrant) begin
      rrPtr <= nextPtr;
    end
  end

  // Label and data hold their last value when nothing is broadcast.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      BCEN    <= 1'b0;
      BClabel <= '0;
      BCdata  <= '0;
    end else begin
      BCEN <= anyGrant;
      if (anyGrant) begin
        BClabel <= slotLabel[grantIdx];
        BCdata  <= slotData[grantIdx];
      end
    end
  end

endmodule

// File: doc/cdb_broadcaster.md
CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, giving the number of functional-unit sources contending for the common data bus.
REQ-002 The block SHALL have parameter LABEL_W, default 5, giving the reservation-station label width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the result data width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 The block SHALL have port nRST, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port reqIn, input, N_SRC bits: per-source result-ready request.
REQ-008 The block SHALL have port labelIn, input, N_SRC*LABEL_W bits: per-source producer label, with source i at slice i.
REQ-009 The block SHALL have port dataIn, input, N_SRC*DATA_W bits: per-source result, with source i at slice i.
REQ-010 The block SHALL have port ackOut, output, N_SRC bits: per-source acceptance of the request.
REQ-011 The block SHALL have port BCEN, output, 1 bit: broadcast valid.
REQ-012 The block SHALL have port BClabel, output, LABEL_W bits: broadcast producer label.
REQ-013 The block SHALL have port BCdata, output, DATA_W bits: broadcast result.

Function
REQ-014 Each source SHALL own a one-entry holding slot with a valid bit, label and data.
REQ-015 ackOut[i] SHALL be combinational: reqIn[i] AND (slot i empty OR slot i granted this cycle).
REQ-016 A request with ackOut[i]=1 and a nonzero label SHALL be captured into slot i at that clock edge.
REQ-017 A request with label 0 (the "no producer" label) SHALL be acked and SHALL NOT be captured or broadcast.
REQ-018 A source SHALL hold reqIn, labelIn and dataIn stable until ackOut is seen; the block does not check this.
REQ-019 Each cycle, the block SHALL grant at most one valid slot using round-robin arbitration starting from the index after the last granted one; the pointer resets to source 0.
REQ-020 On a grant, the block SHALL register BCEN=1, BClabel and BCdata from the granted slot at the clock edge and clear that slot's valid bit at the same edge.
REQ-021 With no valid slot, BCEN SHALL be 0 next cycle, and BClabel and BCdata SHALL hold their previous values.
REQ-022 Minimum latency SHALL be 2 edges: capture at edge N, with BCEN=1 visible after edge N+1.
REQ-023 A slot granted in cycle N SHALL accept a new request in the same cycle, giving 1 result/cycle per source when uncontended.
REQ-024 When all slots are full and none are granted, ackOut SHALL be 0 for every non-granted source (backpressure); no result is ever dropped.
REQ-025 The round-robin pointer SHALL wrap from N_SRC-1 to 0 and advance only on a grant.
REQ-026 Two broadcasts with the same label SHALL both be issued in grant order; the block does not deduplicate.

Reset
REQ-027 Asserting nRST low SHALL, immediately and without a clock, clear all slot valid bits, set BCEN=0, BClabel=0, BCdata=0, and set the round-robin pointer to 0.
REQ-028 A broadcast or capture in flight during reset SHALL be discarded, and ackOut SHALL be driven only by the combinational rule in REQ-015 using the cleared slots.
REQ-029 The first grant after reset release SHALL occur no earlier than the second rising edge after release.

Structure
REQ-030 LABEL_W, DATA_W, N_SRC defaults and the constant NO_LABEL=0 SHALL live in the shared package tomasulo_pkg, which is also used by the instruction queue and reservation stations.
REQ-031 The round-robin selection SHALL be one sub-module, rr_arbiter, with inputs req[N_SRC] and ptr and output one-hot grant.
REQ-032 Slots and the output register SHALL be in the top module, with no further hierarchy.

Verification
REQ-033 Reset, then source 1 sends label=4, data=25 -> ackOut[1]=1 the same cycle; two edges later BCEN=1, BClabel=4, BCdata=25 for exactly one cycle.
REQ-034 Sources 0..3 request simultaneously with labels 1..4 -> broadcasts occur in order 1,2,3,4 on consecutive cycles; a follow-up from source 0 with label 5 broadcasts after label 4 (pointer wrap).
REQ-035 Source 2 holds reqIn high with slots 0,1,3 full and a new label each ack -> source 2 is acked every cycle it is granted, with no label lost or duplicated across 8 results.
REQ-036 Source 0 requests with label 0, data=99 -> ackOut[0]=1 and BCEN stays 0.
REQ-037 nRST pulsed low while slots 0 and 3 are valid -> BCEN=0 at once; after release, no broadcast of the stale labels occurs.
REQ-038 Output feeds the instruction-queue model, where a queued entry waits on label 4 -> the entry's operand becomes 25 after the BCEN cycle carrying label 4.
